// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types and constants for hazard control.
package pipe_pkg;

    localparam int REG_AW_DEFAULT = 5;
    localparam int ZERO_REG       = 0;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hz_loaduse_cmp.sv
// rtl/hz_loaduse_cmp.sv - combinational load-use register compare.
// Also intended for reuse by the forwarding unit.
module hz_loaduse_cmp
    import pipe_pkg::*;
#(
    parameter int AW = REG_AW_DEFAULT
) (
    input  logic          i_memread,
    input  logic [AW-1:0] i_ex_rt,
    input  logic [AW-1:0] i_id_rs,
    input  logic [AW-1:0] i_id_rt,
    output logic          o_hit
);

    logic w_not_zero;
    logic w_match;

    // A load into the zero register never creates a real dependency.
    assign w_not_zero = (i_ex_rt != AW'(ZERO_REG));
    assign w_match    = (i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt);
    assign o_hit      = i_memread && w_not_zero && w_match;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: PC/IF-ID enables and ID/EX flush.
// Optional HAZARD_PERF_CNT_EN adds stall and flush cycle counters.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int REG_AW  = REG_AW_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic              ex_mul_i,
    input  logic              ex_branch_taken_i,
    input  logic              ext_stall_i,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]       stall_cnt_o,
    output logic [15:0]       flush_cnt_o,
`endif
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              idex_flush_o,
    output logic              mul_busy_o
);

    localparam int CNT_W = $clog2(MUL_LAT);

    hz_state_t        r_state;
    hz_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_lu;

    hz_loaduse_cmp #(.AW(REG_AW)) u_lu_cmp (
        .i_memread (ex_memread_i),
        .i_ex_rt   (ex_rt_i),
        .i_id_rs   (id_rs_i),
        .i_id_rt   (id_rt_i),
        .o_hit     (w_lu)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        ifid_flush_o = 1'b0;
        idex_flush_o = 1'b0;
        mul_busy_o   = 1'b0;

        case (r_state)
            RUN: begin
                if (ex_branch_taken_i) begin
                    ifid_flush_o = 1'b1;
                    idex_flush_o = 1'b1;
                end else if (ex_mul_i) begin
                    // The ex_mul_i cycle itself counts towards the MUL_LAT freeze.
                    pc_write_o   = 1'b0;
                    ifid_write_o = 1'b0;
                    idex_flush_o = 1'b1;
                    mul_busy_o   = 1'b1;
                    w_state_nxt  = MUL_WAIT;
                    w_cnt_nxt    = CNT_W'(MUL_LAT - 2);
                end else if (w_lu || ext_stall_i) begin
                    pc_write_o   = 1'b0;
                    ifid_write_o = 1'b0;
                    idex_flush_o = 1'b1;
                end
            end
            MUL_WAIT: begin
                pc_write_o   = 1'b0;
                ifid_write_o = 1'b0;
                idex_flush_o = 1'b1;
                mul_busy_o   = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = '0;
            end
        endcase

        if (!rst_n) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
            mul_busy_o   = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_write_o) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (ifid_flush_o) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule
